ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 17 +
 rtl/ex_muldiv_core.sv | 35 +++
 rtl/ex_muldiv.sv | 86 ++++++++
 tb/tb_ex_muldiv.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: op and FSM encodings shared with the control unit, plus operand magnitude helper.
package ex_muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/ex_muldiv_core.sv
// muldiv_core: 64-bit radix-2 step engine (shift-add multiply, restoring divide) on unsigned operands.
module muldiv_core (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_mul,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_nxt_hi,
  output logic [31:0] o_nxt_lo
);
  logic [31:0] r_hi, r_lo, r_b;
  logic [32:0] w_sum, w_t;
  logic        w_ge;
  // lo holds the multiplier (mul) or the dividend being shifted into the remainder (div)
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_t   = {r_hi, r_lo[31]};
  assign w_ge  = w_t >= {1'b0, r_b};
  assign o_nxt_hi = i_mul ? w_sum[32:1] : 32'(w_ge ? w_t - {1'b0, r_b} : w_t);
  assign o_nxt_lo = i_mul ? {w_sum[0], r_lo[31:1]} : {r_lo[30:0], w_ge};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      r_hi <= o_nxt_hi;
      r_lo <= o_nxt_lo;
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall control.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int CW = $clog2(ITER + 1);
  state_e      r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic        r_div, r_neg_q, r_neg_r, r_dz;
  logic        w_issue, w_step, w_last, w_div, w_sgn;
  logic [31:0] w_rs_mag, w_rt_mag, w_nxt_hi, w_nxt_lo, w_hi_res, w_lo_res;
  logic [63:0] w_prod, w_prod_s;
  assign w_div    = op_e'(op_i) == OP_DIV || op_e'(op_i) == OP_DIVU;
  assign w_sgn    = op_e'(op_i) == OP_MULT || op_e'(op_i) == OP_DIV;
  assign w_issue  = r_state == S_IDLE && start_i;
  assign w_step   = r_state == S_CALC;
  assign w_last   = w_step && r_cnt == CW'(ITER - 1);
  assign stall_o  = w_issue || w_step;
  assign done_o   = r_state == S_DONE;
  assign w_rs_mag = mag(rs_i, w_sgn);
  assign w_rt_mag = mag(rt_i, w_sgn);
  // final results are taken from the core's last-step value so they land on the edge entering DONE
  assign w_prod   = {w_nxt_hi, w_nxt_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_hi_res = r_div ? (r_neg_r ? -w_nxt_hi : w_nxt_hi) : w_prod_s[63:32];
  assign w_lo_res = r_div ? (r_dz ? 32'hFFFF_FFFF : r_neg_q ? -w_nxt_lo : w_nxt_lo) : w_prod_s[31:0];
  muldiv_core u_core (
    .i_clk    (clk_i),
    .i_rst_n  (rst_n_i),
    .i_load   (w_issue),
    .i_step   (w_step),
    .i_mul    (~r_div),
    .i_a      (w_div ? w_rs_mag : w_rt_mag),
    .i_b      (w_div ? w_rt_mag : w_rs_mag),
    .o_nxt_hi (w_nxt_hi),
    .o_nxt_lo (w_nxt_lo)
  );
  always_comb
    w_nxt = w_issue ? S_CALC : w_last ? S_DONE : w_step ? S_CALC : S_IDLE;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)    r_cnt <= '0;
    else if (w_issue) r_cnt <= '0;
    else if (w_step)  r_cnt <= r_cnt + 1'b1;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_issue) begin
      r_div   <= w_div;
      r_neg_q <= w_sgn & (rs_i[31] ^ rt_i[31]);
      r_neg_r <= w_sgn & rs_i[31];
      r_dz    <= rt_i == '0;
    end
  // a start in IDLE wins over MTHI/MTLO strobes in the same cycle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (w_last) begin
      hi_o <= w_hi_res;
      lo_o <= w_lo_res;
    end else if (r_state == S_IDLE && !start_i) begin
      if (hi_we_i) hi_o <= wdata_i;
      if (lo_we_i) lo_o <= wdata_i;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv results, latency, HI/LO writes and reset behaviour.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
  logic        clk_i = 1'b0, rst_n_i = 1'b1, start_i = 1'b0, hi_we_i = 1'b0, lo_we_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_i = '0, rt_i = '0, wdata_i = '0;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;
  int vecs = 0, errs = 0;
  localparam logic [1:0] OPS[12] = '{OP_MULTU, OP_MULT, OP_MULT, OP_DIV, OP_DIVU, OP_DIVU,
                                      OP_DIV, OP_DIV, OP_MULT, OP_DIVU, OP_MULTU, OP_DIV};
  localparam logic [31:0] VA[12] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
                                      32'd100, 32'h0000_1234, 32'd7, 32'hFFFF_FFF9,
                                      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'h8000_0000};
  localparam logic [31:0] VB[12] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd2,
                                      32'd7, 32'd0, 32'hFFFF_FFFE, 32'd0,
                                      32'hFFFF_FFFF, 32'd1, 32'h0001_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] EH[12] = '{32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                      32'd2, 32'h0000_1234, 32'd1, 32'hFFFF_FFF9,
                                      32'd0, 32'd0, 32'd1, 32'd0};
  localparam logic [31:0] EL[12] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFEB, 32'hFFFF_FFFD,
                                      32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                      32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};

  always #5 clk_i = ~clk_i;

  ex_muldiv dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Holds start_i while stalled; optional MTLO at issue, MTLO pulse or operand toggle at stall cycle N.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr_issue, input int mtlo_at, input int tog_at,
                       output int ns, output int nd, output logic [31:0] h, output logic [31:0] l);
    ns = 0;
    nd = 0;
    @(negedge clk_i);
    op_i = op; rs_i = a; rt_i = b; start_i = 1'b1; lo_we_i = wr_issue; wdata_i = 32'hDEAD_BEEF;
    #1;
    while (stall_o && ns < 100) begin
      ns++;
      if (done_o) nd++;
      @(negedge clk_i);
      lo_we_i = (ns == mtlo_at);
      if (ns == tog_at) begin
        rs_i = ~rs_i;
        rt_i = rt_i ^ 32'h5;
      end
      #1;
    end
    if (done_o) nd++;
    h = hi_o;
    l = lo_o;
    start_i = 1'b0;
    lo_we_i = 1'b0;
    @(negedge clk_i);
    #1;
    if (done_o) nd++;
  endtask

  task automatic test_reset();
    #1 rst_n_i = 1'b0;
    #2;
    vecs++; if (hi_o !== 32'd0) begin errs++; $display("FAIL rst_hi: got %h want %h", hi_o, 32'd0); end
    vecs++; if (lo_o !== 32'd0) begin errs++; $display("FAIL rst_lo: got %h want %h", lo_o, 32'd0); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done_o); end
    vecs++; if (stall_o !== 1'b0) begin errs++; $display("FAIL rst_stall_lo: got %b want 0", stall_o); end
    start_i = 1'b1;
    #1;
    vecs++; if (stall_o !== 1'b1) begin errs++; $display("FAIL rst_stall_hi: got %b want 1", stall_o); end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    vecs++; if (stall_o !== 1'b0) begin errs++; $display("FAIL post_rst_stall: got %b want 0", stall_o); end
  endtask

  task automatic test_arith();
    int ns, nd;
    logic [31:0] h, l;
    for (int i = 0; i < 12; i++) begin
      do_op(OPS[i], VA[i], VB[i], 1'b0, 0, 0, ns, nd, h, l);
      vecs++; if (ns != 33) begin errs++; $display("FAIL arith%0d_stall: got %0d want 33", i, ns); end
      vecs++; if (nd != 1) begin errs++; $display("FAIL arith%0d_done: got %0d want 1", i, nd); end
      vecs++; if (h !== EH[i]) begin errs++; $display("FAIL arith%0d_hi: got %h want %h", i, h, EH[i]); end
      vecs++; if (l !== EL[i]) begin errs++; $display("FAIL arith%0d_lo: got %h want %h", i, l, EL[i]); end
    end
  endtask

  task automatic test_hilo_write();
    int ns, nd;
    logic [31:0] h, l;
    do_op(OP_MULTU, 32'd6, 32'd7, 1'b1, 0, 0, ns, nd, h, l);
    vecs++; if (l !== 32'd42) begin errs++; $display("FAIL mtlo_with_start: got %h want %h", l, 32'd42); end
    vecs++; if (h !== 32'd0) begin errs++; $display("FAIL mtlo_with_start_hi: got %h want %h", h, 32'd0); end
    @(negedge clk_i);
    hi_we_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
    #1;
    vecs++; if (hi_o !== 32'd0) begin errs++; $display("FAIL mthi_early: got %h want %h", hi_o, 32'd0); end
    @(negedge clk_i);
    hi_we_i = 1'b0;
    vecs++; if (hi_o !== 32'hA5A5_A5A5) begin errs++; $display("FAIL mthi: got %h want %h", hi_o, 32'hA5A5_A5A5); end
    vecs++; if (lo_o !== 32'd42) begin errs++; $display("FAIL mthi_lo_kept: got %h want %h", lo_o, 32'd42); end
    lo_we_i = 1'b1; wdata_i = 32'h5A5A_5A5A;
    @(negedge clk_i);
    lo_we_i = 1'b0;
    vecs++; if (lo_o !== 32'h5A5A_5A5A) begin errs++; $display("FAIL mtlo: got %h want %h", lo_o, 32'h5A5A_5A5A); end
    do_op(OP_MULTU, 32'd3, 32'd5, 1'b0, 5, 0, ns, nd, h, l);
    vecs++; if (l !== 32'd15) begin errs++; $display("FAIL mtlo_in_calc: got %h want %h", l, 32'd15); end
    vecs++; if (ns != 33) begin errs++; $display("FAIL mtlo_in_calc_stall: got %0d want 33", ns); end
  endtask

  task automatic test_operand_hold();
    int ns, nd;
    logic [31:0] h, l;
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0, 10, ns, nd, h, l);
    vecs++; if (l !== 32'd14) begin errs++; $display("FAIL hold_div_lo: got %h want %h", l, 32'd14); end
    vecs++; if (h !== 32'd2) begin errs++; $display("FAIL hold_div_hi: got %h want %h", h, 32'd2); end
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 3, ns, nd, h, l);
    vecs++; if (l !== 32'hFFFF_FFEB) begin errs++; $display("FAIL hold_mul_lo: got %h want %h", l, 32'hFFFF_FFEB); end
    vecs++; if (h !== 32'hFFFF_FFFF) begin errs++; $display("FAIL hold_mul_hi: got %h want %h", h, 32'hFFFF_FFFF); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk_i);
    op_i = OP_MULTU; rs_i = 32'd6; rt_i = 32'd7; start_i = 1'b1;
    #1;
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    vecs++; if (n != 33) begin errs++; $display("FAIL b2b_first_stall: got %0d want 33", n); end
    vecs++; if (lo_o !== 32'd42) begin errs++; $display("FAIL b2b_first_lo: got %h want %h", lo_o, 32'd42); end
    op_i = OP_DIVU; rs_i = 32'd100; rt_i = 32'd7;
    @(negedge clk_i);
    #1;
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL b2b_idle_done: got %b want 0", done_o); end
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    vecs++; if (n != 33) begin errs++; $display("FAIL b2b_second_stall: got %0d want 33", n); end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL b2b_second_done: got %b want 1", done_o); end
    vecs++; if (lo_o !== 32'd14) begin errs++; $display("FAIL b2b_second_lo: got %h want %h", lo_o, 32'd14); end
    vecs++; if (hi_o !== 32'd2) begin errs++; $display("FAIL b2b_second_hi: got %h want %h", hi_o, 32'd2); end
    start_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_calc();
    int nd = 0;
    @(negedge clk_i);
    op_i = OP_DIVU; rs_i = 32'h0000_FFFF; rt_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk_i);
    vecs++; if (stall_o !== 1'b1) begin errs++; $display("FAIL mid_calc_stall: got %b want 1", stall_o); end
    rst_n_i = 1'b0;
    #1;
    vecs++; if (hi_o !== 32'd0) begin errs++; $display("FAIL mid_rst_hi: got %h want %h", hi_o, 32'd0); end
    vecs++; if (lo_o !== 32'd0) begin errs++; $display("FAIL mid_rst_lo: got %h want %h", lo_o, 32'd0); end
    vecs++; if (stall_o !== 1'b1) begin errs++; $display("FAIL mid_rst_stall_start: got %b want 1", stall_o); end
    start_i = 1'b0;
    #1;
    vecs++; if (stall_o !== 1'b0) begin errs++; $display("FAIL mid_rst_stall_idle: got %b want 0", stall_o); end
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) nd++;
    end
    vecs++; if (nd != 0) begin errs++; $display("FAIL mid_rst_no_done: got %0d want 0", nd); end
    vecs++; if (hi_o !== 32'd0) begin errs++; $display("FAIL post_mid_rst_hi: got %h want %h", hi_o, 32'd0); end
    vecs++; if (lo_o !== 32'd0) begin errs++; $display("FAIL post_mid_rst_lo: got %h want %h", lo_o, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_hilo_write();
    test_operand_hold();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
